// File: rtl/loader_scan_controller.sv
// Raster-order scan controller for the image loader: walks Col/Row over one frame,
// issues read addresses under valid/ready, and flags full 3x3 Sobel windows.
// Optional feature macro: LOADER_AUTO_RESTART_EN (continuous frame scanning until Abort).
module loader_scan_controller #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int COL_BITS   = 8,
  parameter int ROW_BITS   = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic                  Ready,
  output logic [ADDR_WIDTH-1:0] Addr,
  output logic                  Addr_Valid,
  output logic [COL_BITS-1:0]   Col,
  output logic [ROW_BITS-1:0]   Row,
  output logic                  Window_Valid,
  output logic                  Busy,
  output logic                  Done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [COL_BITS-1:0]   COL_LAST = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0]   ROW_LAST = ROW_BITS'(IMG_HEIGHT - 1);
  localparam logic [COL_BITS-1:0]   COL_ONE  = COL_BITS'(1);
  localparam logic [ROW_BITS-1:0]   ROW_ONE  = ROW_BITS'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t state, state_next;
  logic   handshake;
  logic   last_col;
  logic   last_pix;

  // Addr_Valid is high exactly while in RUN, so it doubles as the RUN qualifier.
  assign handshake = Addr_Valid & Ready;
  assign last_col  = (Col == COL_LAST);
  assign last_pix  = last_col & (Row == ROW_LAST);

  assign Window_Valid = Addr_Valid & (Row >= ROW_BITS'(2)) & (Col >= COL_BITS'(2));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (handshake && last_pix) state_next = DONE;
`ifdef LOADER_AUTO_RESTART_EN
      DONE:    state_next = RUN;
`else
      DONE:    state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
    if (Abort) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      Addr       <= '0;
      Col        <= '0;
      Row        <= '0;
      Addr_Valid <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state      <= state_next;
      Addr_Valid <= (state_next == RUN);
      Busy       <= (state_next == RUN);
      Done       <= (state_next == DONE);
      // Counters are zero on every RUN entry because they clear whenever RUN is left.
      if (state_next != RUN) begin
        Addr <= '0;
        Col  <= '0;
        Row  <= '0;
      end else if (state == RUN && handshake) begin
        Addr <= Addr + ADDR_ONE;
        if (last_col) begin
          Col <= '0;
          Row <= Row + ROW_ONE;
        end else begin
          Col <= Col + COL_ONE;
        end
      end
    end
  end

endmodule
